edge_stretcher: RTL and testbench

Converts single-cycle edge pulses (as produced by the positive-edge detector) back into level pulses of programmable width, with an enforced minimum low gap between pulses. Edges that arrive while a pulse is in progress are either queued or extend the current pulse, depending on mode. It sits downstream of edge detection and drives level-sensitive consumers such as latch enables and strobes.

---
 rtl/edge_stretcher_pkg.sv | 16 +
 rtl/edge_stretcher_if.sv | 30 +++
 rtl/edge_stretcher_cycle_down_counter.sv | 29 ++
 rtl/edge_stretcher.sv | 160 ++++++++++++++++
 tb/tb_edge_stretcher.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/edge_stretcher_pkg.sv
// Shared types and helpers for the edge stretcher: FSM state encoding and the
// width rule for the pending-edge counter.
package edge_stretcher_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      GAP  = 2'd2
   } state_t;

   // Bits needed to count 0..max_pending queued edges.
   function automatic int pend_width(input int max_pending);
      return (max_pending < 1) ? 1 : $clog2(max_pending + 1);
   endfunction

endpackage

// File: rtl/edge_stretcher_if.sv
// Bundle of the edge stretcher's control inputs and status outputs.
// The master side drives edges and settings; the slave side is the stretcher.
interface edge_stretcher_if #(
   parameter int WIDTH_BITS  = 8,
   parameter int MAX_PENDING = 3
);
   import edge_stretcher_pkg::*;

   localparam int PW = pend_width(MAX_PENDING);

   logic                  EdgeIn;
   logic [WIDTH_BITS-1:0] Length;
   logic                  Retrigger;
   logic                  ClearOverflow;
   logic                  Level;
   logic                  Busy;
   logic [PW-1:0]         PendingCount;
   logic                  Overflow;

   modport master (
      output EdgeIn, Length, Retrigger, ClearOverflow,
      input  Level, Busy, PendingCount, Overflow
   );

   modport slave (
      input  EdgeIn, Length, Retrigger, ClearOverflow,
      output Level, Busy, PendingCount, Overflow
   );

endinterface

// File: rtl/edge_stretcher_cycle_down_counter.sv
// Loadable down-counter used for both the high time and the gap time.
// 'last' flags the final cycle of a loaded interval (count of 1, or idle at 0).
module cycle_down_counter #(
   parameter int WIDTH_BITS = 8
) (
   input  logic                  Clock,
   input  logic                  nReset,
   input  logic                  load,
   input  logic [WIDTH_BITS-1:0] load_value,
   input  logic                  enable,
   output logic                  last
);

   logic [WIDTH_BITS-1:0] count;

   // Load takes priority; otherwise step down toward zero while enabled.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable && (count != '0)) begin
         count <= count - WIDTH_BITS'(1);
      end
   end

   assign last = (count <= WIDTH_BITS'(1));

endmodule

// File: rtl/edge_stretcher.sv
// Turns single-cycle edge pulses into level pulses of programmable width with
// an enforced low gap between pulses. Edges arriving mid-pulse either reload
// the high time (retrigger mode) or are counted into a saturating queue.
module edge_stretcher
   import edge_stretcher_pkg::*;
#(
   parameter int WIDTH_BITS  = 8,
   parameter int GAP_CYCLES  = 1,
   parameter int MAX_PENDING = 3
) (
   input  logic               Clock,
   input  logic               nReset,
   edge_stretcher_if.slave    bus
);

   localparam int                    PW       = pend_width(MAX_PENDING);
   localparam logic [PW-1:0]         PEND_MAX = PW'(MAX_PENDING);
   localparam logic [WIDTH_BITS-1:0] GAP_LOAD = WIDTH_BITS'(GAP_CYCLES);
   localparam bit                    HAS_GAP  = (GAP_CYCLES != 0);

   state_t                state;
   logic                  level_q;
   logic                  busy_q;
   logic                  ovf_q;
   logic                  rt_q;
   logic [PW-1:0]         pend_q;

   logic [WIDTH_BITS-1:0] len_eff;
   logic                  start;
   logic                  reload;
   logic                  enq;
   logic                  deq;
   logic                  drop;
   logic                  high_last;
   logic                  gap_last;
   logic                  high_done;
   logic                  gap_done;
   logic                  high_load;
   logic                  gap_load;

   // Decode what this cycle's edge and queue state mean for the FSM and queue.
   always_comb begin
      len_eff   = (bus.Length == '0) ? WIDTH_BITS'(1) : bus.Length;
      start     = 1'b0;
      reload    = 1'b0;
      enq       = 1'b0;
      case (state)
         IDLE: begin
            // An edge arriving while older edges wait joins the back of the queue.
            start = bus.EdgeIn || (pend_q != '0);
            enq   = bus.EdgeIn && (pend_q != '0);
         end
         HIGH: begin
            reload = bus.EdgeIn && rt_q;
            enq    = bus.EdgeIn && !rt_q;
         end
         GAP: begin
            enq = bus.EdgeIn;
         end
         default: begin
            start = 1'b0;
         end
      endcase
      deq       = start && (pend_q != '0);
      drop      = enq && !deq && (pend_q == PEND_MAX);
      high_done = (state == HIGH) && high_last && !reload;
      gap_done  = (state == GAP) && gap_last;
      high_load = start || reload;
      gap_load  = high_done && HAS_GAP;
   end

   cycle_down_counter #(.WIDTH_BITS(WIDTH_BITS)) u_high_cnt (
      .Clock      (Clock),
      .nReset     (nReset),
      .load       (high_load),
      .load_value (len_eff),
      .enable     (state == HIGH),
      .last       (high_last)
   );

   cycle_down_counter #(.WIDTH_BITS(WIDTH_BITS)) u_gap_cnt (
      .Clock      (Clock),
      .nReset     (nReset),
      .load       (gap_load),
      .load_value (GAP_LOAD),
      .enable     (state == GAP),
      .last       (gap_last)
   );

   // Pulse FSM with registered Level/Busy; retrigger mode is latched at each load.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state   <= IDLE;
         level_q <= 1'b0;
         busy_q  <= 1'b0;
         rt_q    <= 1'b0;
      end else begin
         if (high_load) begin
            rt_q <= bus.Retrigger;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= HIGH;
                  level_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            HIGH: begin
               if (high_done) begin
                  level_q <= 1'b0;
                  if (HAS_GAP) begin
                     state  <= GAP;
                     busy_q <= 1'b1;
                  end else begin
                     state  <= IDLE;
                     busy_q <= 1'b0;
                  end
               end
            end
            GAP: begin
               if (gap_done) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               level_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Saturating pending-edge count and sticky overflow; setting beats clearing.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         pend_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (enq && !deq && !drop) begin
            pend_q <= pend_q + PW'(1);
         end else if (deq && !enq) begin
            pend_q <= pend_q - PW'(1);
         end
         if (drop) begin
            ovf_q <= 1'b1;
         end else if (bus.ClearOverflow) begin
            ovf_q <= 1'b0;
         end
      end
   end

   assign bus.Level        = level_q;
   assign bus.Busy         = busy_q;
   assign bus.PendingCount = pend_q;
   assign bus.Overflow     = ovf_q;

endmodule

// File: tb/tb_edge_stretcher.sv
// Bench for edge_stretcher: a time-based model (pulse end / gap end as absolute
// cycle numbers plus an integer queue count) is compared every cycle, and
// directed scenarios pin the model with hand-computed waveforms.
module tb_edge_stretcher;

   localparam int WB   = 8;
   localparam int GAPC = 2;
   localparam int MAXP = 3;

   logic Clock  = 1'b0;
   logic nReset = 1'b0;

   always #5 Clock = ~Clock;

   edge_stretcher_if #(.WIDTH_BITS(WB), .MAX_PENDING(MAXP)) bus ();

   edge_stretcher #(
      .WIDTH_BITS (WB),
      .GAP_CYCLES (GAPC),
      .MAX_PENDING(MAXP)
   ) dut (
      .Clock (Clock),
      .nReset(nReset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // model state
   int t      = 0;
   int m_end  = -1000;
   int m_pend = 0;
   bit m_ovf  = 1'b0;
   bit m_rt   = 1'b0;
   bit e_level = 1'b0;
   bit e_busy  = 1'b0;
   int e_pend  = 0;
   bit e_ovf   = 1'b0;
   bit model_ok = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: a pulse started or reloaded at edge c stays high through
   // cycle c+len; the following GAPC cycles are busy-low; then idle.
   initial begin : model
      int len;
      bit e, in_high, in_gap, enq, drop;
      forever begin
         @(posedge Clock);
         if (!nReset) begin
            m_end = -1000; m_pend = 0; m_ovf = 1'b0; m_rt = 1'b0;
            e_level = 1'b0; e_busy = 1'b0; e_pend = 0; e_ovf = 1'b0;
            model_ok = 1'b1;
         end else begin
            e       = bus.EdgeIn;
            len     = (bus.Length == '0) ? 1 : int'(bus.Length);
            in_high = (t <= m_end);
            in_gap  = !in_high && (t <= m_end + GAPC);
            enq     = 1'b0;
            if (in_high) begin
               if (e) begin
                  if (m_rt) begin
                     m_end = t + len;
                     m_rt  = bus.Retrigger;
                  end else begin
                     enq = 1'b1;
                  end
               end
            end else if (in_gap) begin
               enq = e;
            end else if (e || m_pend > 0) begin
               m_end = t + len;
               m_rt  = bus.Retrigger;
               if (!e) m_pend--;
            end
            drop = enq && (m_pend == MAXP);
            if (enq && !drop) m_pend++;
            m_ovf = drop ? 1'b1 : (bus.ClearOverflow ? 1'b0 : m_ovf);
            t++;
            e_level = (t <= m_end);
            e_busy  = (t <= m_end + GAPC);
            e_pend  = m_pend;
            e_ovf   = m_ovf;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   initial begin : compare
      forever begin
         @(negedge Clock);
         if (nReset && model_ok) begin
            check("level",    32'(bus.Level),        32'(e_level));
            check("busy",     32'(bus.Busy),         32'(e_busy));
            check("pending",  32'(bus.PendingCount), 32'(e_pend));
            check("overflow", 32'(bus.Overflow),     32'(e_ovf));
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input bit e, input int len, input bit rt, input bit clr);
      bus.EdgeIn        = e;
      bus.Length        = WB'(len);
      bus.Retrigger     = rt;
      bus.ClearOverflow = clr;
      @(negedge Clock);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((bus.Busy || bus.PendingCount != '0) && n < 200) begin
         tick(1'b0, 1, 1'b0, 1'b0);
         n++;
      end
      check({name, "_idle_timeout"}, 32'(n < 200), 32'd1);
      tick(1'b0, 1, 1'b0, 1'b0);
   endtask

   initial begin : stim
      logic [31:0] lv, bv;
      int pmax;
      bit any_level;

      bus.EdgeIn = 1'b0; bus.Length = '0; bus.Retrigger = 1'b0; bus.ClearOverflow = 1'b0;
      nReset = 1'b0;
      repeat (3) @(negedge Clock);
      check("rst_level",    32'(bus.Level),        32'd0);
      check("rst_busy",     32'(bus.Busy),         32'd0);
      check("rst_pending",  32'(bus.PendingCount), 32'd0);
      check("rst_overflow", 32'(bus.Overflow),     32'd0);
      nReset = 1'b1;
      repeat (2) tick(1'b0, 1, 1'b0, 1'b0);

      // single pulse, Length=4: high 4 cycles, then 2 gap cycles
      wait_idle("s1");
      lv = '0; bv = '0;
      tick(1'b1, 4, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         lv[i] = bus.Level; bv[i] = bus.Busy;
         tick(1'b0, 4, 1'b0, 1'b0);
      end
      check("s1_level_shape", lv, 32'h0F);
      check("s1_busy_shape",  bv, 32'h3F);

      // Length=0 acts as 1
      wait_idle("s2");
      lv = '0;
      tick(1'b1, 0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         lv[i] = bus.Level;
         tick(1'b0, 0, 1'b0, 1'b0);
      end
      check("s2_len0_shape", lv, 32'h1);

      // retrigger: edges at 0 and 3 with Length=5 keep Level high cycles 1..8
      wait_idle("s3");
      lv = '0; pmax = 0;
      for (int s = 0; s < 11; s++) begin
         tick((s == 0) || (s == 3), 5, 1'b1, 1'b0);
         lv[s] = bus.Level;
         if (int'(bus.PendingCount) > pmax) pmax = int'(bus.PendingCount);
      end
      check("s3_retrig_shape", lv, 32'h0FF);
      check("s3_pend_max",     32'(pmax), 32'd0);

      // queued edges: three pulses spaced by GAPC+1 low cycles
      wait_idle("s4");
      lv = '0; pmax = 0;
      for (int s = 0; s < 18; s++) begin
         tick(s < 3, 3, 1'b0, 1'b0);
         lv[s] = bus.Level;
         if (int'(bus.PendingCount) > pmax) pmax = int'(bus.PendingCount);
      end
      check("s4_queue_shape", lv, 32'h071C7);
      check("s4_pend_max",    32'(pmax), 32'd2);

      // overflow: five edges during one long pulse, then clear behaviour
      wait_idle("s5");
      tick(1'b1, 10, 1'b0, 1'b0);
      for (int s = 1; s <= 5; s++) tick(1'b1, 10, 1'b0, 1'b0);
      check("s5_pend_full", 32'(bus.PendingCount), 32'd3);
      check("s5_ovf_set",   32'(bus.Overflow),     32'd1);
      tick(1'b1, 10, 1'b0, 1'b1);
      check("s5_ovf_set_beats_clear", 32'(bus.Overflow),     32'd1);
      check("s5_pend_hold",           32'(bus.PendingCount), 32'd3);
      tick(1'b0, 10, 1'b0, 1'b1);
      check("s5_ovf_cleared", 32'(bus.Overflow), 32'd0);

      // async reset mid-pulse discards the queue; nothing restarts afterwards
      wait_idle("s6");
      tick(1'b1, 8, 1'b0, 1'b0);
      tick(1'b1, 8, 1'b0, 1'b0);
      tick(1'b1, 8, 1'b0, 1'b0);
      bus.EdgeIn = 1'b0;
      check("s6_pend_before", 32'(bus.PendingCount), 32'd2);
      check("s6_level_before", 32'(bus.Level), 32'd1);
      #2 nReset = 1'b0;
      #1;
      check("s6_rst_level", 32'(bus.Level),        32'd0);
      check("s6_rst_pend",  32'(bus.PendingCount), 32'd0);
      check("s6_rst_busy",  32'(bus.Busy),         32'd0);
      @(negedge Clock);
      @(negedge Clock);
      nReset = 1'b1;
      any_level = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick(1'b0, 8, 1'b0, 1'b0);
         any_level = any_level | bus.Level;
      end
      check("s6_no_pulse_after_reset", 32'(any_level), 32'd0);

      // randomized traffic with bursts and one asynchronous reset
      for (int i = 0; i < 3000; i++) begin
         bit burst;
         burst = ((i / 100) % 3) == 1;
         tick(($urandom_range(0, 99) < (burst ? 60 : 18)),
              int'($urandom_range(0, 6)),
              ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 15) == 0));
         if (i == 1500) begin
            #2 nReset = 1'b0;
            #1;
            check("rnd_rst_level", 32'(bus.Level),        32'd0);
            check("rnd_rst_pend",  32'(bus.PendingCount), 32'd0);
            @(negedge Clock);
            nReset = 1'b1;
         end
      end
      wait_idle("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
